// File: rtl/video_cache_writer.sv
// video_cache_writer: unpacks 3-byte/2-pixel packets into sequential 12-bit RAM writes.
// Writes are registered one cycle behind the completing byte; overflow sticks until frame_done.
module video_cache_writer #(
    parameter int RAM_SIZE  = 1024,
    parameter int COLOR_LEN = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inclk,
    input  logic [7:0]                  in,
    input  logic                        in_done,
    output logic                        ram_writeclk,
    output logic [$clog2(RAM_SIZE)-1:0] ram_waddr,
    output logic [COLOR_LEN-1:0]        ram_win,
    output logic                        frame_done,
    output logic                        overflow
);
    localparam int AW = $clog2(RAM_SIZE);

    typedef enum logic [1:0] {PH0, PH1, PH2} phase_t;

    phase_t              r_phase;
    phase_t              w_phase_nxt;
    phase_t              w_adv;
    logic [7:0]          r_hi;
    logic [3:0]          r_nib;
    logic [AW:0]         r_addr;
    logic                r_wr;
    logic [AW-1:0]       r_waddr;
    logic [COLOR_LEN-1:0] r_win;
    logic                r_frame_done;
    logic                r_overflow;
    logic                w_pix_done;
    logic                w_full;
    logic                w_wr;
    logic [11:0]         w_pix;

    always_ff @(posedge clk) begin
        if (rst)
            r_phase <= PH0;
        else
            r_phase <= w_phase_nxt;
    end

    // The extra counter bit lets the address reach RAM_SIZE without wrapping.
    always_comb begin
        w_adv       = r_phase == PH0 ? PH1 : r_phase == PH1 ? PH2 : PH0;
        w_phase_nxt = in_done ? PH0 : inclk ? w_adv : r_phase;
        w_pix_done  = inclk && r_phase != PH0;
        w_pix       = r_phase == PH1 ? {r_hi, in[7:4]} : {r_nib, in};
        w_full      = r_addr == (AW+1)'(RAM_SIZE);
        w_wr        = w_pix_done && !w_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi         <= '0;
            r_nib        <= '0;
            r_addr       <= '0;
            r_wr         <= 1'b0;
            r_waddr      <= '0;
            r_win        <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (inclk && r_phase == PH0)
                r_hi <= in;
            if (inclk && r_phase == PH1)
                r_nib <= in[3:0];
            r_addr <= in_done ? '0 : w_wr ? r_addr + 1'b1 : r_addr;
            r_wr   <= w_wr;
            if (w_wr) begin
                r_waddr <= r_addr[AW-1:0];
                r_win   <= COLOR_LEN'(w_pix);
            end
            r_frame_done <= in_done;
            r_overflow   <= r_frame_done ? 1'b0 : r_overflow | (w_pix_done & w_full);
        end
    end

    assign ram_writeclk = r_wr;
    assign ram_waddr    = r_waddr;
    assign ram_win      = r_win;
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;
endmodule

// File: doc/video_cache_writer.md
VIDEO_CACHE_WRITER -- requirements
Module: video_cache_writer

Interface
REQ-001 The block SHALL have parameter RAM_SIZE, default 1024, giving the number of pixels in the video cache RAM (32x32 image).
REQ-002 The block SHALL have parameter COLOR_LEN, default 12, giving the pixel width in bits (4 bits each of R, G, B, MSB first).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port inclk, input, 1 bit: byte-valid strobe; in is consumed on every cycle where inclk=1.
REQ-006 Port in, input, 8 bits: packet payload byte.
REQ-007 Port in_done, input, 1 bit: end-of-packet strobe, one cycle wide.
REQ-008 Port ram_writeclk, output, 1 bit: RAM write enable.
REQ-009 Port ram_waddr, output, clog2(RAM_SIZE) bits: RAM write address, with layout {y[4:0], x[4:0]}.
REQ-010 Port ram_win, output, COLOR_LEN bits: RAM write data.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse marking the end of a frame.
REQ-012 Port overflow, output, 1 bit: sticky flag; the current packet carried more than RAM_SIZE pixels.

Function
REQ-013 Each packet SHALL be one frame, packed at two pixels per three bytes: B0=p0[11:4], B1={p0[3:0],p1[11:8]}, B2=p1[7:0].
REQ-014 The byte-phase state machine SHALL have states PH0, PH1 and PH2, and SHALL advance one state per accepted byte, wrapping PH0->PH1->PH2->PH0.
REQ-015 In PH0 the block SHALL hold the byte as hi. In PH1 it SHALL write pixel {hi, in[7:4]} and hold in[3:0]. In PH2 it SHALL write pixel {held nibble, in}.
REQ-016 Writes SHALL be registered. ram_writeclk, ram_waddr and ram_win SHALL be valid exactly one cycle after the inclk cycle that completes a pixel.
REQ-017 ram_writeclk SHALL be high for exactly one cycle per written pixel and low at all other times.
REQ-018 The pixel address counter SHALL start at 0, increment by 1 after each write, and be clog2(RAM_SIZE)+1 bits wide so that it does not wrap.
REQ-019 When the counter equals RAM_SIZE, no further writes SHALL occur, overflow SHALL be set, and the byte-phase machine SHALL keep advancing.
REQ-020 On in_done the block SHALL return to PH0, clear the address counter to 0, and discard any partial pixel without writing it.
REQ-021 frame_done SHALL pulse high for one cycle, one cycle after in_done.
REQ-022 If inclk and in_done are high in the same cycle, the byte SHALL be processed first, including any write it completes, and the end-of-packet action SHALL then apply.
REQ-023 overflow SHALL remain set until the cycle in which frame_done pulses, and SHALL clear in the cycle after that.
REQ-024 If in_done arrives with no bytes received, the block SHALL pulse frame_done and SHALL perform no write.
REQ-025 The block SHALL accept inclk on back-to-back cycles with no stall. There is no backpressure output.

Reset
REQ-026 While rst=1, the block SHALL be in PH0 with the address counter at 0 and the held registers at 0.
REQ-027 While rst=1, ram_writeclk, frame_done and overflow SHALL all be 0, and ram_waddr and ram_win SHALL be 0.
REQ-028 When rst is asserted mid-packet, any partial pixel SHALL be discarded. The next accepted byte SHALL be treated as B0 of a new frame, written at address 0.

Verification
REQ-029 Bytes AB CD EF on consecutive cycles, then in_done -> write ABC at address 0 one cycle after CD, write DEF at address 1 one cycle after EF, frame_done one cycle after in_done, overflow=0.
REQ-030 1536 bytes (a full 32x32 frame) with random gaps in inclk -> exactly 1024 writes at addresses 0..1023 in order, data matching the model, no overflow.
REQ-031 1539 bytes -> 1024 writes, overflow=1 after the 1025th pixel completes. After in_done, overflow clears, and the next packet writes from address 0.
REQ-032 Bytes 12 34 with in_done asserted together with 34 -> one write of 123 at address 0, nibble 4 discarded, frame_done the following cycle. The next byte 56 is treated as B0.
REQ-033 rst pulsed after the B1 of pixel 5 -> no stray write. The next bytes 11 22 33 write 112 at address 0 and 233 at address 1.
REQ-034 in_done with no preceding bytes -> frame_done pulses, ram_writeclk stays 0, overflow stays 0.
